// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encodings, oversampling constants
// and helper functions for the baud divider and the three-sample majority vote.
// No ports. Imported by the receiver top; the divider helper is shared with the transmitter.
package uart_pkg;

  // Receiver state encodings.
  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Samples per bit. The sample counter is 4 bits wide, so only 16 is supported.
  localparam int unsigned OVERSAMPLE = 16;

  // Sample indices within a bit: three mid-bit votes and the last sample.
  localparam logic [3:0] SMP_VOTE_A = 4'd7;
  localparam logic [3:0] SMP_VOTE_B = 4'd8;
  localparam logic [3:0] SMP_VOTE_C = 4'd9;
  localparam logic [3:0] SMP_LAST   = 4'd15;

  // Clocks per sample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// UART receive-side bundle: serial line in, byte/error strobes out.
// Latency: none (wires only). Backpressure: none; strobes are fire-and-forget.
// Ports: rx (line), rx_vld/rx_data (good byte), rx_ferr/rx_break (error strobes).
// master = the receiver; slave = the line driver plus the byte consumer.
interface uart_rx_os16_if;
  logic       rx;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_break;

  modport master (
    input  rx,
    output rx_vld,
    output rx_data,
    output rx_ferr,
    output rx_break
  );

  modport slave (
    output rx,
    input  rx_vld,
    input  rx_data,
    input  rx_ferr,
    input  rx_break
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Sample tick generator: one-clk tick every DIV clocks; clr restarts the period.
// Latency: first tick DIV clocks after clr is released. Backpressure: none.
// Ports: clk, rst (async, active-high), clr (sync restart), tick (one-clk pulse).
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// UART 8N1 receiver, 16x oversampled, mid-bit majority vote; byte and error strobes.
// Latency: strobe 154 sample ticks after the start edge at rx_s, plus 2 sync clocks.
// Backpressure: none; rx_vld/rx_ferr/rx_break are single-clk strobes, rx_data holds.
// Ports: clk, rst (async, active-high), bus (uart_rx_os16_if.master):
//   rx in; rx_vld, rx_data[7:0], rx_ferr, rx_break out.
module uart_rx_os16 #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_os16_if.master bus
);
  import uart_pkg::*;

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);

  // Input synchronizer plus one history flop for start-edge detection.
  logic rx_meta;
  logic rx_s;
  logic rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  uart_state_t state;
  logic [3:0]  samp_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        smp_a;
  logic        smp_b;
  logic        vbit;
  logic        vld_q;
  logic        ferr_q;
  logic        brk_q;
  logic [7:0]  data_q;

  logic start_edge;
  logic tick;
  logic clr;

  assign start_edge = rx_prev & ~rx_s;
  // Restart the tick period on the start edge so sample 0 begins at the edge.
  assign clr = (state == IDLE) && start_edge;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_HIGH;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      smp_a    <= 1'b0;
      smp_b    <= 1'b0;
      vbit     <= 1'b0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;

      // Sample counter and vote capture run on every tick; the vote over
      // samples 7/8/9 is settled before the end-of-bit decision at sample 15.
      if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        case (samp_cnt)
          SMP_VOTE_A: smp_a <= rx_s;
          SMP_VOTE_B: smp_b <= rx_s;
          SMP_VOTE_C: vbit  <= maj3(smp_a, smp_b, rx_s);
          default: ;
        endcase
      end

      case (state)
        // Requiring the line high on a sample tick gives the synchronizer time
        // to flush its reset value, so a line held low is never seen as idle.
        WAIT_HIGH: begin
          if (tick && rx_s) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (start_edge) begin
            samp_cnt <= 4'd0;
            state    <= START;
          end
        end

        START: begin
          if (tick && (samp_cnt == SMP_LAST)) begin
            if (vbit) begin
              state <= IDLE;
            end else begin
              bit_cnt <= 3'd0;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (tick && (samp_cnt == SMP_LAST)) begin
            shift   <= {vbit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end

        // Decide mid-stop so the next start edge of a back-to-back frame is
        // already watched for in IDLE. The vote uses the live sample 9.
        STOP: begin
          if (tick && (samp_cnt == SMP_VOTE_C)) begin
            if (maj3(smp_a, smp_b, rx_s)) begin
              vld_q  <= 1'b1;
              data_q <= shift;
              state  <= IDLE;
            end else begin
              ferr_q <= 1'b1;
              brk_q  <= (shift == 8'h00);
              state  <= WAIT_HIGH;
            end
          end
        end

        default: state <= WAIT_HIGH;
      endcase
    end
  end

  assign bus.rx_vld   = vld_q;
  assign bus.rx_data  = data_q;
  assign bus.rx_ferr  = ferr_q;
  assign bus.rx_break = brk_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: frame driver, strobe scoreboard, vector table and
// hand-written corner sequences (glitch, framing error, break, sample flip, reset).
module tb_uart_rx_os16;
  import uart_pkg::*;

  localparam int unsigned TB_CLK  = 100_000_000;
  localparam int unsigned TB_BAUD = 921_600;
  localparam int DIV = (TB_CLK + TB_BAUD * 8) / (TB_BAUD * 16);
  localparam int BIT = 16 * DIV;
  localparam int LAT = 154 * DIV + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os16_if bus ();

  uart_rx_os16 #(
    .CLK_FREQ (TB_CLK),
    .BAUD     (TB_BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       vld;
    logic       ferr;
    logic       brk;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       stop;
    logic       e_vld;
    logic       e_ferr;
    logic       e_brk;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int strobe_cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.rx_vld || bus.rx_ferr || bus.rx_break)) begin
      strobe_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got vld=%0b ferr=%0b brk=%0b data=0x%02h, want no strobe",
                 bus.rx_vld, bus.rx_ferr, bus.rx_break, bus.rx_data);
      end else begin
        e = sb.pop_front();
        check("strobe_vld", 32'(bus.rx_vld), 32'(e.vld));
        check("strobe_ferr", 32'(bus.rx_ferr), 32'(e.ferr));
        check("strobe_break", 32'(bus.rx_break), 32'(e.brk));
        if (e.vld) check("strobe_data", 32'(bus.rx_data), 32'(e.data));
      end
    end
  end

  task automatic expect_good(input logic [7:0] d);
    sb.push_back('{vld: 1'b1, ferr: 1'b0, brk: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic expect_ferr(input logic brk);
    sb.push_back('{vld: 1'b0, ferr: 1'b1, brk: brk, data: 8'h00});
  endtask

  task automatic drain(input string name);
    check({"pending_", name}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  // One 8N1 frame. flip_bit >= 0 inverts the line around sample 8 of that data bit only.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int flip_bit);
    bus.rx = 1'b0;
    edge_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      if (i == flip_bit) begin
        repeat (8 * DIV + 3) @(negedge clk);
        bus.rx = ~d[i];
        repeat (2 * DIV - 6) @(negedge clk);
        bus.rx = d[i];
        repeat (6 * DIV + 3) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    bus.rx = stop;
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{d: 8'h00, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};
    tbl[1] = '{d: 8'hFF, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};
    tbl[2] = '{d: 8'h80, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};
    tbl[3] = '{d: 8'h01, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};
    tbl[4] = '{d: 8'hC3, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};
    tbl[5] = '{d: 8'h00, stop: 1'b0, e_vld: 1'b0, e_ferr: 1'b1, e_brk: 1'b1};
    tbl[6] = '{d: 8'h3C, stop: 1'b0, e_vld: 1'b0, e_ferr: 1'b1, e_brk: 1'b0};
    tbl[7] = '{d: 8'h80, stop: 1'b0, e_vld: 1'b0, e_ferr: 1'b1, e_brk: 1'b0};
    tbl[8] = '{d: 8'h5A, stop: 1'b1, e_vld: 1'b1, e_ferr: 1'b0, e_brk: 1'b0};

    // Reset state.
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_vld", 32'(bus.rx_vld), 32'd0);
    check("reset_ferr", 32'(bus.rx_ferr), 32'd0);
    check("reset_break", 32'(bus.rx_break), 32'd0);
    check("reset_data", 32'(bus.rx_data), 32'd0);
    check("reset_state", 32'(dut.state), 32'(WAIT_HIGH));
    rst = 1'b0;
    idle_bits(2);

    // Single frame with latency window.
    expect_good(8'h41);
    send_frame(8'h41, 1'b1, -1);
    idle_bits(1);
    drain("frame_41");
    lat = strobe_cyc - edge_cyc;
    n_vec++;
    if (lat < LAT - DIV || lat > LAT + DIV) begin
      n_err++;
      $display("FAIL latency_41: got %0d clk, want %0d +/- %0d clk", lat, LAT, DIV);
    end

    // Back-to-back frames, no idle gap.
    expect_good(8'h0A);
    expect_good(8'h77);
    send_frame(8'h0A, 1'b1, -1);
    send_frame(8'h77, 1'b1, -1);
    idle_bits(1);
    drain("b2b");
    check("b2b_data_hold", 32'(bus.rx_data), 32'h77);

    // Short low glitch must be rejected, then a normal frame.
    bus.rx = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    idle_bits(2);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    expect_good(8'h31);
    send_frame(8'h31, 1'b1, -1);
    idle_bits(1);
    drain("after_glitch");

    // Framing error: rx_data keeps the last good byte.
    expect_ferr(1'b0);
    send_frame(8'h55, 1'b0, -1);
    check("ferr_data_hold", 32'(bus.rx_data), 32'h31);
    idle_bits(2);
    drain("ferr_55");

    // Break: 20 bit times low gives exactly one error pulse.
    expect_ferr(1'b1);
    bus.rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    idle_bits(2);
    drain("break");
    expect_good(8'h72);
    send_frame(8'h72, 1'b1, 3);
    idle_bits(1);
    drain("flip_72");

    // Reset mid-frame with the line still low afterwards.
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = ((8'hA5 >> i) & 8'h01) != 8'h00;
      repeat (BIT) @(negedge clk);
    end
    bus.rx = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_vld", 32'(bus.rx_vld), 32'd0);
    check("midrst_ferr", 32'(bus.rx_ferr), 32'd0);
    check("midrst_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("midrst_wait_high", 32'(dut.state), 32'(WAIT_HIGH));
    idle_bits(2);
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle_bits(1);
    drain("after_rst");

    // Vector table.
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].e_vld) expect_good(tbl[v].d);
      else sb.push_back('{vld: 1'b0, ferr: tbl[v].e_ferr, brk: tbl[v].e_brk, data: 8'h00});
      send_frame(tbl[v].d, tbl[v].stop, -1);
      idle_bits(2);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_data", v), 32'(bus.rx_data), 32'(last_good));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
